// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle RV64I control unit: FSM states,
// instruction classes, opcode/funct fields and datapath select codes.
package controle_pkg;

    typedef enum logic [3:0] {
        S_FETCH0, S_FETCH1, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
        S_MEM_ADDR, S_LD_READ, S_LD_MDR, S_LD_WB, S_SD_WRITE, S_LUI_WB,
        S_BRANCH, S_PC_INC, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LD, C_SD, C_BR, C_LUI, C_EBREAK, C_ILLEGAL
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_SD     = 7'b0100011;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic [2:0] SRCB_REGB  = 3'd0;
    localparam logic [2:0] SRCB_FOUR  = 3'd1;
    localparam logic [2:0] SRCB_IMM   = 3'd2;
    localparam logic [2:0] SRCB_IMMSH = 3'd3;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_IMM    = 2'd2;

endpackage

// File: rtl/decodificador_instr.sv
// Combinational instruction classifier: opcode plus funct3/funct7 validity
// yields an instruction class and the ALU operation used in execute.
import controle_pkg::*;

module decodificador_instr (
    input  logic [31:0] inst,
    output iclass_t     iclass,
    output logic [2:0]  alu_op
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = inst[6:0];
    assign funct3        = inst[14:12];
    assign funct7        = inst[31:25];
    assign unused_fields = ^{inst[24:15], inst[11:7]};

    always_comb begin
        iclass = C_ILLEGAL;
        alu_op = ALU_ADD;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD && funct7 == F7_BASE) begin
                    iclass = C_R;
                end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    iclass = C_R;
                    alu_op = ALU_SUB;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    iclass = C_R;
                    alu_op = ALU_AND;
                end
            end
            OP_I:      if (funct3 == F3_ADD) iclass = C_I;
            OP_LD:     if (funct3 == F3_D)   iclass = C_LD;
            OP_SD:     if (funct3 == F3_D)   iclass = C_SD;
            OP_BR: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    iclass = C_BR;
                    alu_op = ALU_SUB;
                end
            end
            OP_LUI:    iclass = C_LUI;
            OP_SYSTEM: iclass = C_EBREAK;
            default:   iclass = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle Moore control FSM for the RV64I processing unit: sequences
// fetch/decode/execute/memory/write-back and halts on ebreak or bad encodings.
import controle_pkg::*;

module unidade_controle (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] inst,
    input  logic        zero,
    output logic        PCSrc,
    output logic [2:0]  ALUFunct,
    output logic        ALUSrcA,
    output logic [2:0]  ALUSrcB,
    output logic        LoadRegA,
    output logic        LoadRegB,
    output logic        LoadALUOut,
    output logic        LoadIR,
    output logic        LoadMDR,
    output logic        WriteReg,
    output logic [1:0]  MemToReg,
    output logic        IMemWrite,
    output logic        DMemWrite,
    output logic        BranchOp,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        halted,
    output logic        illegal
);
    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    iclass_t    iclass;
    logic [2:0] alu_op;
    logic       is_bne;

    decodificador_instr u_dec (
        .inst   (inst),
        .iclass (iclass),
        .alu_op (alu_op)
    );

    assign is_bne = (inst[14:12] == F3_BNE);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_FETCH0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q | (state_q == S_DECODE && iclass == C_ILLEGAL);
        case (state_q)
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    C_R:      state_d = S_EXEC_R;
                    C_I:      state_d = S_EXEC_I;
                    C_LD,
                    C_SD:     state_d = S_MEM_ADDR;
                    C_BR:     state_d = S_BRANCH;
                    C_LUI:    state_d = S_LUI_WB;
                    default:  state_d = S_HALT;
                endcase
            end
            S_EXEC_R,
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (iclass == C_SD) ? S_SD_WRITE : S_LD_READ;
            S_LD_READ:  state_d = S_LD_MDR;
            S_LD_MDR:   state_d = S_LD_WB;
            S_WB_ALU,
            S_LD_WB,
            S_SD_WRITE,
            S_LUI_WB:   state_d = S_PC_INC;
            // Branch target was latched in ALUOut during DECODE
            S_BRANCH:   state_d = (zero ^ is_bne) ? S_FETCH0 : S_PC_INC;
            S_PC_INC:   state_d = S_FETCH0;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
    end

    always_comb begin
        PCSrc       = 1'b0;
        ALUFunct    = ALU_PASS;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        LoadRegA    = 1'b0;
        LoadRegB    = 1'b0;
        LoadALUOut  = 1'b0;
        LoadIR      = 1'b0;
        LoadMDR     = 1'b0;
        WriteReg    = 1'b0;
        MemToReg    = M2R_ALUOUT;
        DMemWrite   = 1'b0;
        BranchOp    = 1'b0;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        case (state_q)
            S_FETCH1: LoadIR = 1'b1;
            S_DECODE: begin
                LoadRegA   = 1'b1;
                LoadRegB   = 1'b1;
                LoadALUOut = 1'b1;
                ALUSrcB    = SRCB_IMMSH;
                ALUFunct   = ALU_ADD;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUFunct   = alu_op;
                LoadALUOut = 1'b1;
            end
            S_EXEC_I,
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUFunct   = ALU_ADD;
                LoadALUOut = 1'b1;
            end
            S_WB_ALU:   WriteReg = 1'b1;
            S_LD_MDR:   LoadMDR  = 1'b1;
            S_LD_WB: begin
                WriteReg = 1'b1;
                MemToReg = M2R_MDR;
            end
            S_SD_WRITE: DMemWrite = 1'b1;
            S_LUI_WB: begin
                WriteReg = 1'b1;
                MemToReg = M2R_IMM;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUFunct    = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = 1'b1;
                BranchOp    = is_bne;
            end
            S_PC_INC: begin
                ALUSrcB  = SRCB_FOUR;
                ALUFunct = ALU_ADD;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
        // A reset landing mid-instruction must not commit any state
        if (Reset) begin
            LoadRegA    = 1'b0;
            LoadRegB    = 1'b0;
            LoadALUOut  = 1'b0;
            LoadIR      = 1'b0;
            LoadMDR     = 1'b0;
            WriteReg    = 1'b0;
            DMemWrite   = 1'b0;
            PCWriteCond = 1'b0;
            PCWrite     = 1'b0;
        end
    end

    assign IMemWrite = 1'b0;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control FSM that sequences the 64-bit RISC-V processing unit. Each cycle it decodes the current state and the instruction-register contents into the datapath's load, write and mux-select strobes. It implements fetch, decode, execute, memory and write-back for an RV64I subset, and halts on `ebreak` or on an illegal encoding. It sits beside the processing unit in the CPU top: `inst` and `zero` come in, and every control strobe goes out.

## Interface
No parameters.
- `clk`  in  1  single system clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `inst`  in  32  IR contents (`Instr31_0`).
- `zero`  in  1  ALU zero flag (combinational, current cycle).
- `PCSrc`  out  1  0 = ALU result, 1 = ALUOut register.
- `ALUFunct`  out  3  000 pass A, 001 ADD, 010 SUB, 011 AND, 110 XOR.
- `ALUSrcA`  out  1  0 = PC, 1 = RegA.
- `ALUSrcB`  out  3  0 RegB, 1 const 4, 2 sign-ext imm, 3 imm<<1.
- `LoadRegA`, `LoadRegB`, `LoadALUOut`, `LoadIR`, `LoadMDR`  out  1 each  register loads.
- `WriteReg`  out  1  register file write.
- `MemToReg`  out  2  0 ALUOut, 1 MDR, 2 sign-ext imm (lui).
- `IMemWrite`  out  1  tied 0.
- `DMemWrite`  out  1  data memory write.
- `BranchOp`  out  1  0 = take on `zero`, 1 = take on `!zero`.
- `PCWriteCond`, `PCWrite`  out  1 each  PC load qualifiers.
- `halted`  out  1  FSM is in HALT.
- `illegal`  out  1  HALT was entered through an illegal encoding (sticky).

## Operation
- Moore FSM with 4-bit state: FETCH0, FETCH1, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, LD_READ, LD_MDR, LD_WB, SD_WRITE, LUI_WB, BRANCH, PC_INC, HALT.
- Every output not listed for a state is 0.
- FETCH0: IMem address (PC) settles; no strobes. Next state FETCH1.
- FETCH1: `LoadIR`. Next state DECODE.
- DECODE: `LoadRegA`, `LoadRegB`, `LoadALUOut`, ALUSrcA=0, ALUSrcB=3, ADD. This precomputes the branch target PC+imm. Dispatch on `inst[6:0]`:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 0110111 → LUI_WB
  - 1110011 → HALT
  - anything else → HALT with `illegal`=1
- Decoded but unsupported funct3/funct7 also goes to HALT with `illegal`=1.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, `LoadALUOut`.
  - funct3 000 with funct7 0000000 → ADD; funct7 0100000 → SUB.
  - funct3 111 → AND.
- EXEC_I (addi, funct3 000): ALUSrcA=1, ALUSrcB=2, ADD, `LoadALUOut`.
- WB_ALU: `WriteReg`, MemToReg=0. Next state PC_INC.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD, `LoadALUOut`. Next state LD_READ (ld, funct3 011) or SD_WRITE (sd, funct3 011).
- LD_READ: address settles. LD_MDR: `LoadMDR`. LD_WB: `WriteReg`, MemToReg=1.
- SD_WRITE: `DMemWrite`.
- LUI_WB: `WriteReg`, MemToReg=2.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, `PCWriteCond`, PCSrc=1. BranchOp=0 for beq (funct3 000), 1 for bne (001).
  - Taken (`zero` XOR BranchOp = 1) → FETCH0.
  - Not taken → PC_INC.
- PC_INC: ALUSrcA=0, ALUSrcB=1, ADD, PCSrc=0, `PCWrite`. Next state FETCH0.
- HALT: absorbing; all strobes 0; `halted`=1. Only `Reset` exits.

## Timing
- Cycles per instruction, counted from FETCH0 to the next FETCH0: R / addi 6, ld 8, sd 6, lui 5, branch taken 4, branch not taken 5.
- Memories read synchronously: data is valid one cycle after the address is stable. This is why FETCH0/FETCH1 and LD_READ/LD_MDR are separate states.
- `Reset` sampled high: state←FETCH0 and `illegal`←0 at that edge.
- While `Reset` is high, every load/write strobe is forced to 0 combinationally, so a mid-instruction reset never commits a write.
- Output values after reset (FETCH0): all strobes 0, `halted`=0, `illegal`=0.
- `zero` is used only in BRANCH, in the same cycle, for the next-state decision.
- At most one of `WriteReg`, `DMemWrite`, `PCWrite` is asserted in any cycle.

## Structure
- Package `controle_pkg` holds:
  - the state enum
  - opcode, funct3 and funct7 constants
  - ALUFunct, ALUSrcB and MemToReg code constants
- Sub-module `decodificador_instr`: combinational. Maps `inst` to an instruction-class enum (R, I, LD, SD, BR, LUI, EBREAK, ILLEGAL) plus an ALU op.
- Top contains the state register, next-state logic and output decode.

## Test plan
- Reset held 2 cycles, then released → state FETCH0, all outputs 0. FETCH1 asserts `LoadIR` on the 2nd cycle after release.
- `add x3,x1,x2` (0x002081B3) → EXEC_R shows ALUFunct=001 and ALUSrcB=0. WB_ALU shows `WriteReg`=1. `PCWrite` is asserted in cycle 6.
- `ld x5,8(x1)` (0x0080B283) → `LoadMDR` in cycle 6, `WriteReg` with MemToReg=1 in cycle 7, `PCWrite` in cycle 8. `DMemWrite` is never asserted.
- `beq x1,x2,+16` with `zero`=1 → `PCWriteCond`=1, PCSrc=1, next state FETCH0 (4 cycles). Same instruction with `zero`=0 → PC_INC (5 cycles).
- Opcode 0x7F, then `ebreak` (0x00100073) after a reset → first case gives `halted`=1, `illegal`=1, strobes 0 for 20 cycles. Second case gives `halted`=1, `illegal`=0.
- `Reset` asserted in SD_WRITE → `DMemWrite`=0 in that cycle; state is FETCH0 on the next cycle.
